// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage RISC-V pipeline: mispredict flush, load-use
// bubbles via a hold FSM, freeze on data-memory wait, and saturating perf counters.
module hazard_ctrl #(
  parameter int XLEN   = 32,
  parameter int LU_CYC = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  ex_PC,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_pc_target,
  input  logic             mem_hit,
  input  logic             mem_pred,
  input  logic             mem_taken,
  input  logic [1:0]       mem_jump,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             dmem_ready,
  output logic             flush,
  output logic             stall,
  output logic             freeze,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int HC_W = 3;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(LU_CYC - 1);
  localparam bit MULTI_CYC = (LU_CYC > 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [HC_W-1:0] hold_q, hold_d;

  logic taken_eff;
  logic pred_hit;
  logic jalr_bad_tgt;
  logic mispredict;
  logic rs1_used;
  logic rs2_used;
  logic hazard;

  // Mispredict resolution for the instruction currently in MEM
  always_comb begin
    taken_eff    = mem_taken | mem_jump[1];
    pred_hit     = mem_pred & mem_hit;
    jalr_bad_tgt = (mem_jump == 2'b11) & pred_hit & (mem_pc_target != ex_PC);
    mispredict   = mem_valid & ((~taken_eff & pred_hit) |
                                (taken_eff & ~pred_hit) |
                                jalr_bad_tgt);
  end

  // Register-use decode for the ID instruction and load-use detection
  always_comb begin
    rs1_used = (id_opcode != OP_JAL) & (id_opcode != OP_LUI) & (id_opcode != OP_AUIPC);
    rs2_used = (id_opcode == OP_R) | (id_opcode == OP_S) | (id_opcode == OP_B);
    hazard   = ex_memread & (ex_rd != 5'd0) &
               ((rs1_used & (id_rs1 == ex_rd)) | (rs2_used & (id_rs2 == ex_rd)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: a frozen cycle leaves the FSM untouched
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (!freeze) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!flush && hazard && MULTI_CYC) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q <= HC_W'(1)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d  = hold_q - HC_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Outputs are forced low during reset even though they are combinational
  always_comb begin
    freeze = ~reset & ~dmem_ready;
    flush  = ~reset & ~freeze & mispredict;
    stall  = ~reset & ~freeze & ~flush & ((state_q == ST_IDLE) ? hazard : 1'b1);
  end

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [2];

  assign cnt_inc = {stall, flush};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
          cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign mispred_cnt = cnt_q[0];
  assign stall_cnt   = cnt_q[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LU_CYC=1, LU_CYC=3, LU_CYC=3 with
// 4-bit counters) share one stimulus bus; each check targets one instance.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_PC;
  logic        mem_valid;
  logic [31:0] mem_pc_target;
  logic        mem_hit;
  logic        mem_pred;
  logic        mem_taken;
  logic [1:0]  mem_jump;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        dmem_ready;

  logic        f1, s1, z1, f3, s3, z3, fs, ss, zs;
  logic [15:0] mc1, sc1, mc3, sc3;
  logic [3:0]  mcs, scs;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .LU_CYC(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .ex_PC(ex_PC), .mem_valid(mem_valid),
    .mem_pc_target(mem_pc_target), .mem_hit(mem_hit), .mem_pred(mem_pred),
    .mem_taken(mem_taken), .mem_jump(mem_jump), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .dmem_ready(dmem_ready), .flush(f1), .stall(s1), .freeze(z1),
    .mispred_cnt(mc1), .stall_cnt(sc1));

  hazard_ctrl #(.XLEN(32), .LU_CYC(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .ex_PC(ex_PC), .mem_valid(mem_valid),
    .mem_pc_target(mem_pc_target), .mem_hit(mem_hit), .mem_pred(mem_pred),
    .mem_taken(mem_taken), .mem_jump(mem_jump), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .dmem_ready(dmem_ready), .flush(f3), .stall(s3), .freeze(z3),
    .mispred_cnt(mc3), .stall_cnt(sc3));

  hazard_ctrl #(.XLEN(32), .LU_CYC(3), .CNT_W(4)) dut3s (
    .clk(clk), .reset(reset), .ex_PC(ex_PC), .mem_valid(mem_valid),
    .mem_pc_target(mem_pc_target), .mem_hit(mem_hit), .mem_pred(mem_pred),
    .mem_taken(mem_taken), .mem_jump(mem_jump), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .dmem_ready(dmem_ready), .flush(fs), .stall(ss), .freeze(zs),
    .mispred_cnt(mcs), .stall_cnt(scs));

  typedef struct {
    logic        memread;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        valid;
    logic        hit;
    logic        pred;
    logic        taken;
    logic [1:0]  jump;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        ready;
    logic [2:0]  exp;   // {flush, stall, freeze}
  } vec_t;

  typedef struct {
    int         which;
    logic [2:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [2:0] outs(input int which);
    case (which)
      0:       return {f1, s1, z1};
      1:       return {f3, s3, z3};
      default: return {fs, ss, zs};
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic addv(input logic memread, input logic [4:0] rd, input logic [6:0] opc,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic valid,
                      input logic hit, input logic pred, input logic taken,
                      input logic [1:0] jump, input logic [31:0] tgt, input logic [31:0] pc,
                      input logic ready, input logic [2:0] exp);
    vec_t v;
    v.memread = memread; v.rd = rd; v.opc = opc; v.rs1 = rs1; v.rs2 = rs2;
    v.valid = valid; v.hit = hit; v.pred = pred; v.taken = taken; v.jump = jump;
    v.tgt = tgt; v.pc = pc; v.ready = ready; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive_vec(input vec_t v);
    ex_memread = v.memread; ex_rd = v.rd; id_opcode = v.opc; id_rs1 = v.rs1;
    id_rs2 = v.rs2; mem_valid = v.valid; mem_hit = v.hit; mem_pred = v.pred;
    mem_taken = v.taken; mem_jump = v.jump; mem_pc_target = v.tgt; ex_PC = v.pc;
    dmem_ready = v.ready;
  endtask

  task automatic set_idle();
    ex_memread = 0; ex_rd = 0; id_opcode = OP_I; id_rs1 = 0; id_rs2 = 0;
    mem_valid = 0; mem_hit = 0; mem_pred = 0; mem_taken = 0; mem_jump = 2'b00;
    mem_pc_target = 0; ex_PC = 0; dmem_ready = 1;
  endtask

  task automatic set_hazard(input logic memread);
    ex_memread = memread; ex_rd = 5'd5; id_opcode = OP_R; id_rs1 = 5'd5; id_rs2 = 5'd1;
  endtask

  task automatic set_mispred(input logic on);
    mem_valid = on; mem_hit = on; mem_pred = on; mem_taken = 0; mem_jump = 2'b00;
  endtask

  // Inputs already driven; expectation goes through the scoreboard and is
  // checked on the falling edge, then time advances to just after the next rise.
  task automatic step(input string name, input int which, input logic [2:0] exp);
    sb_t e;
    logic [2:0] got;
    e.which = which; e.exp = exp;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    got = outs(e.which);
    n_cmp++;
    if (got !== e.exp) begin
      n_err++;
      $display("FAIL %s dut%0d: {flush,stall,freeze} got %b required %b", name, e.which, got, e.exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1;
    set_idle();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    int exp_fl;
    int exp_st;

    // Reset holds outputs low even with hazard, mispredict and freeze requested
    reset = 1;
    set_idle();
    set_hazard(1);
    set_mispred(1);
    dmem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_dut1", int'(outs(0)), 0);
    chk("rst_outs_dut3", int'(outs(1)), 0);
    chk("rst_cnt_dut1", int'({mc1, sc1}), 0);
    chk("rst_cnt_dut3s", int'({mcs, scs}), 0);
    @(posedge clk); #1 reset = 0;
    set_idle();

    // Single-cycle decode table, LU_CYC=1 (FSM never leaves IDLE)
    addv(1, 5, OP_R,     5, 1, 0,0,0,0,2'b00, 0, 0, 1, 3'b010);
    addv(0, 5, OP_R,     5, 1, 0,0,0,0,2'b00, 0, 0, 1, 3'b000);
    addv(1, 0, OP_R,     0, 0, 0,0,0,0,2'b00, 0, 0, 1, 3'b000);
    addv(1, 5, OP_LUI,   5, 5, 0,0,0,0,2'b00, 0, 0, 1, 3'b000);
    addv(1, 5, OP_AUIPC, 5, 5, 0,0,0,0,2'b00, 0, 0, 1, 3'b000);
    addv(1, 7, OP_S,     5, 7, 0,0,0,0,2'b00, 0, 0, 1, 3'b010);
    addv(1, 7, OP_I,     3, 7, 0,0,0,0,2'b00, 0, 0, 1, 3'b000);
    addv(1, 7, OP_I,     7, 0, 0,0,0,0,2'b00, 0, 0, 1, 3'b010);
    addv(1, 7, OP_JAL,   7, 7, 0,0,0,0,2'b00, 0, 0, 1, 3'b000);
    addv(1, 9, OP_B,     2, 9, 0,0,0,0,2'b00, 0, 0, 1, 3'b010);
    addv(0, 0, OP_I,     0, 0, 1,1,1,0,2'b00, 0, 0, 1, 3'b100);
    addv(0, 0, OP_I,     0, 0, 0,1,1,0,2'b00, 0, 0, 1, 3'b000);
    addv(0, 0, OP_I,     0, 0, 1,1,1,0,2'b11, 32'h100, 32'h104, 1, 3'b100);
    addv(0, 0, OP_I,     0, 0, 1,1,1,0,2'b11, 32'h104, 32'h104, 1, 3'b000);
    addv(0, 0, OP_I,     0, 0, 1,0,0,1,2'b00, 0, 0, 1, 3'b100);
    addv(0, 0, OP_I,     0, 0, 1,0,1,1,2'b00, 0, 0, 1, 3'b100);
    addv(0, 0, OP_I,     0, 0, 1,1,1,1,2'b00, 0, 0, 1, 3'b000);
    addv(0, 0, OP_I,     0, 0, 1,1,1,0,2'b10, 32'h200, 32'h104, 1, 3'b000);
    addv(1, 5, OP_R,     5, 1, 1,1,1,0,2'b00, 0, 0, 1, 3'b100);
    addv(1, 5, OP_R,     5, 1, 1,1,1,0,2'b00, 0, 0, 0, 3'b001);

    exp_fl = 0;
    exp_st = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive_vec(tbl[i]);
      step($sformatf("vec%0d", i), 0, tbl[i].exp);
      exp_fl += int'(tbl[i].exp[2]);
      exp_st += int'(tbl[i].exp[1]);
    end
    set_idle();
    chk("tbl_mispred_cnt", int'(mc1), exp_fl);
    chk("tbl_stall_cnt", int'(sc1), exp_st);

    // LU_CYC=3: three bubbles although ex_memread drops after the first
    do_reset();
    set_hazard(1);
    step("lu3_c1", 1, 3'b010);
    set_hazard(0);
    step("lu3_c2", 1, 3'b010);
    step("lu3_c3", 1, 3'b010);
    step("lu3_c4", 1, 3'b000);
    chk("lu3_stall_cnt", int'(sc3), 3);
    chk("lu3_mispred_cnt", int'(mc3), 0);

    // Mispredict arriving in HOLD cuts the bubble short
    do_reset();
    set_hazard(1);
    step("cut_c1", 1, 3'b010);
    set_hazard(0);
    set_mispred(1);
    step("cut_flush", 1, 3'b100);
    set_mispred(0);
    step("cut_after1", 1, 3'b000);
    step("cut_after2", 1, 3'b000);
    chk("cut_stall_cnt", int'(sc3), 1);
    chk("cut_mispred_cnt", int'(mc3), 1);

    // Freeze during HOLD stretches the stall but keeps the bubble count
    do_reset();
    set_hazard(1);
    step("frz_c1", 1, 3'b010);
    set_hazard(0);
    set_mispred(1);
    dmem_ready = 0;
    for (int i = 0; i < 4; i++) step($sformatf("frz_hold%0d", i), 1, 3'b001);
    chk("frz_stall_cnt_mid", int'(sc3), 1);
    chk("frz_mispred_cnt_mid", int'(mc3), 0);
    set_mispred(0);
    dmem_ready = 1;
    step("frz_c2", 1, 3'b010);
    step("frz_c3", 1, 3'b010);
    step("frz_done", 1, 3'b000);
    chk("frz_stall_cnt", int'(sc3), 3);

    // Saturation with 4-bit counters
    do_reset();
    set_hazard(1);
    for (int i = 0; i < 20; i++) step($sformatf("sat_st%0d", i), 2, 3'b010);
    chk("sat_stall_cnt", int'(scs), 15);
    set_hazard(0);
    set_mispred(1);
    for (int i = 0; i < 20; i++) step($sformatf("sat_fl%0d", i), 2, 3'b100);
    chk("sat_mispred_cnt", int'(mcs), 15);
    chk("sat_stall_cnt_hold", int'(scs), 15);
    set_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised successor to the pipeline hazard unit for the 5-stage RISC-V core. It resolves branch/jump mispredicts from MEM into a one-cycle flush. It detects load-use hazards and holds the pipeline for a configurable number of bubble cycles using a small FSM. It also freezes the whole pipeline while data memory is not ready, and keeps saturating performance counters for mispredicts and stall cycles.

Parameters:
XLEN, 32, PC/target width
LU_CYC, 1, load-use bubble cycles required (legal 1..7)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  synchronous, active-high reset
ex_PC  in  XLEN  PC of the instruction in EX
mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
mem_pc_target  in  XLEN  resolved target of the MEM instruction
mem_hit  in  1  BTB hit recorded for the MEM instruction
mem_pred  in  1  predicted-taken recorded for the MEM instruction
mem_taken  in  1  branch resolved taken
mem_jump  in  2  [1]=jump; 2'b11=JALR
id_opcode  in  7  opcode in ID
id_rs1  in  5  rs1 in ID
id_rs2  in  5  rs2 in ID
ex_memread  in  1  EX instruction is a load
ex_rd  in  5  rd of the EX instruction
dmem_ready  in  1  data memory can complete this cycle
flush  out  1  kill IF/ID and ID/EX contents, redirect PC
stall  out  1  hold PC and IF/ID, inject bubble into ID/EX
freeze  out  1  hold every pipeline register
mispred_cnt  out  CNT_W  mispredicts taken
stall_cnt  out  CNT_W  cycles with stall=1

Behaviour:
- Reset values: flush=0, stall=0, freeze=0, both counters=0, FSM=IDLE, hold counter=0. While reset=1, all outputs are held at these values regardless of inputs.
- Derived signals (combinational):
  - te = mem_taken | mem_jump[1]
  - ph = mem_pred & mem_hit
  - mispredict = mem_valid & ((!te & ph) | (te & !ph) | (mem_jump==2'b11 & ph & mem_pc_target!=ex_PC))
- rs1 is used unless id_opcode is JAL (1101111), LUI (0110111) or AUIPC (0010111).
- rs2 is used only for R (0110011), S (0100011) and B (1100011) opcodes.
- hazard = ex_memread & ex_rd!=0 & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)). x0 never causes a stall.
- Priority each cycle: freeze > flush > stall.
  - freeze = !dmem_ready. While freeze=1: flush=0, stall=0, FSM and hold counter unchanged, counters unchanged.
  - flush = mispredict & !freeze. Combinational, same cycle, pulse only.
  - stall = !freeze & !flush & (FSM==IDLE ? hazard : 1).
- FSM states:
  - IDLE:
    - hazard & !flush & !freeze & LU_CYC>1 -> HOLD, hold counter loaded with LU_CYC-1.
    - With LU_CYC=1 the FSM stays in IDLE (single-cycle bubble).
  - HOLD:
    - stall=1. Hazard is not re-evaluated, because the bubble has cleared ex_memread.
    - Each non-frozen cycle the hold counter decrements. When it reaches 1 and decrements, return to IDLE.
    - flush in HOLD -> IDLE immediately, hold counter=0, stall=0 that cycle.
- Counters:
  - mispred_cnt += 1 on each cycle with flush=1.
  - stall_cnt += 1 on each cycle with stall=1.
  - Both saturate at all-ones and never wrap.
- Total bubble cycles per load-use hazard = LU_CYC, unless cut short by flush.
- A freeze during HOLD extends the stall in wall-clock time only; the bubble count is unchanged.
- A mispredict with mem_valid=0 is ignored.

Test Plan:
1. LU_CYC=1: lw x5 in EX (ex_memread=1, ex_rd=5) with add x6,x5,x1 in ID -> stall=1 for exactly 1 cycle, FSM stays IDLE, stall_cnt=1.
2. LU_CYC=3: same hazard, ex_memread drops after the first cycle -> stall=1 for 3 consecutive cycles, then 0; stall_cnt=3.
3. Hazard with ex_rd=0, or id_opcode=LUI with id_rs1==ex_rd -> stall=0. sw x7,0(x5) with ex_rd=7 (rs2 match) -> stall=1.
4. Branch with mem_pred=1, mem_hit=1, mem_taken=0, mem_valid=1 -> flush=1 for one cycle, mispred_cnt=1. Same case with mem_valid=0 -> flush=0. JALR with ph=1, target=0x100, ex_PC=0x104 -> flush=1.
5. LU_CYC=3, in HOLD at count 2, mispredict arrives -> flush=1 and stall=0 that cycle, FSM returns to IDLE, no further stall.
6. dmem_ready=0 for 4 cycles during HOLD -> freeze=1, stall=0, counters frozen. After release, the remaining stall cycles complete, for a total stall_cnt=LU_CYC. Preload stall_cnt to 0xFFFF, then stall -> count stays 0xFFFF.
